// File: rtl/voice_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : voice_mode_ctrl
// Purpose  : Debounced switch conditioning, click-free mode switching with a
//            fade-out / switch / flush / fade-in sequence, and play-path gain.
// Revision : 1.0 - initial release
// ============================================================================
module voice_mode_ctrl #(
  parameter int DEB_CYCLES   = 100000,
  parameter int GAIN_W       = 8,
  parameter int FADE_STEP    = 8,
  parameter int FLUSH_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_change,
  input  logic        sw_rise,
  input  logic        frame_ready,
  input  logic [15:0] dry_sample,
  input  logic [15:0] wet_sample,
  output logic        change_en,
  output logic        rising_tone,
  output logic        proc_reset,
  output logic [15:0] out_sample,
  output logic        out_valid,
  output logic        busy
);

  localparam int                  c_CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [c_CNT_W-1:0]  c_DEB_LAST   = c_CNT_W'(DEB_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
  localparam int                  c_FL_W       = $clog2(FLUSH_FRAMES + 1);
  localparam logic [c_FL_W-1:0]   c_FLUSH_LAST = c_FL_W'(FLUSH_FRAMES - 1);
  localparam logic [c_FL_W-1:0]   c_FL_ONE     = c_FL_W'(1);
  localparam logic [GAIN_W:0]     c_FULL       = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0]     c_STEP       = (GAIN_W + 1)'(FADE_STEP);
  localparam int                  c_PROD_W     = 16 + GAIN_W + 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_SWITCH   = 3'd2,
    S_FLUSH    = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_req;
  logic [1:0] w_applied;

  assign w_raw     = {sw_change, sw_rise};
  assign w_applied = {change_en, rising_tone};

  // Bit 1 conditions the effect-enable switch, bit 0 the rising-tone switch.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic               r_s1;
      logic               r_s2;
      logic               r_s2_d;
      logic               r_deb;
      logic [c_CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1   <= 1'b0;
          r_s2   <= 1'b0;
          r_s2_d <= 1'b0;
          r_deb  <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_s1   <= w_raw[gi];
          r_s2   <= r_s1;
          r_s2_d <= r_s2;
          if (r_s2 != r_s2_d)
            r_cnt <= '0;
          else if (r_cnt != c_DEB_LAST)
            r_cnt <= r_cnt + c_CNT_ONE;
          else
            r_deb <= r_s2;
        end
      end

      assign w_req[gi] = r_deb;
    end
  endgenerate

  state_t             r_state;
  logic [GAIN_W:0]    r_gain;
  logic [c_FL_W-1:0]  r_flush_cnt;
  logic [15:0]        w_sel;
  logic [GAIN_W:0]    w_gain_dn;
  logic [GAIN_W:0]    w_gain_up;
  logic signed [c_PROD_W-1:0] w_sel_ext;
  logic signed [c_PROD_W-1:0] w_gain_ext;
  logic signed [c_PROD_W-1:0] w_prod;
  logic                       w_unused_prod;

  assign w_sel      = change_en ? wet_sample : dry_sample;
  assign w_gain_dn  = (r_gain > c_STEP) ? (r_gain - c_STEP) : '0;
  assign w_gain_up  = (r_gain >= (c_FULL - c_STEP)) ? c_FULL : (r_gain + c_STEP);
  assign w_sel_ext  = {{(GAIN_W + 2){w_sel[15]}}, w_sel};
  assign w_gain_ext = {{(c_PROD_W - GAIN_W - 1){1'b0}}, r_gain};
  assign w_prod     = w_sel_ext * w_gain_ext;
  // Taking bits [GAIN_W +: 16] is the arithmetic shift; gain <= full scale keeps it in range.
  assign w_unused_prod = ^{w_prod[c_PROD_W-1:GAIN_W+16], w_prod[GAIN_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gain      <= c_FULL;
      r_flush_cnt <= '0;
      change_en   <= 1'b0;
      rising_tone <= 1'b0;
      proc_reset  <= 1'b0;
      out_sample  <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      proc_reset <= 1'b0;
      out_valid  <= frame_ready;
      if (frame_ready)
        out_sample <= w_prod[GAIN_W +: 16];

      case (r_state)
        S_IDLE: begin
          if (w_req != w_applied) begin
            r_state <= S_FADE_OUT;
            busy    <= 1'b1;
          end
        end
        S_FADE_OUT: begin
          if (frame_ready)
            r_gain <= w_gain_dn;
          if (r_gain == '0)
            r_state <= S_SWITCH;
          else if (w_req == w_applied)
            r_state <= S_FADE_IN;
        end
        S_SWITCH: begin
          // Mode and datapath clear land together on the first flush cycle.
          change_en   <= w_req[1];
          rising_tone <= w_req[0];
          proc_reset  <= 1'b1;
          r_flush_cnt <= '0;
          r_state     <= S_FLUSH;
        end
        S_FLUSH: begin
          if (frame_ready) begin
            if (r_flush_cnt == c_FLUSH_LAST)
              r_state <= S_FADE_IN;
            else
              r_flush_cnt <= r_flush_cnt + c_FL_ONE;
          end
        end
        S_FADE_IN: begin
          if (frame_ready)
            r_gain <= w_gain_up;
          if (r_gain == c_FULL) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (w_req != w_applied) begin
            r_state <= S_FADE_OUT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_voice_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for voice_mode_ctrl: directed switch/frame stimulus with a queued
// expected-sample scoreboard drained by an independent output monitor.
module tb_voice_mode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_change;
  logic        sw_rise;
  logic        frame_ready;
  logic [15:0] dry_sample;
  logic [15:0] wet_sample;
  logic        change_en;
  logic        rising_tone;
  logic        proc_reset;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        busy;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   pr_count = 0;
  logic pr_chg   = 1'b0;
  logic pr_rise  = 1'b0;
  int   exp_q[$];

  always #5 clk = ~clk;

  voice_mode_ctrl #(
    .DEB_CYCLES  (4),
    .GAIN_W      (8),
    .FADE_STEP   (64),
    .FLUSH_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_change  (sw_change),
    .sw_rise    (sw_rise),
    .frame_ready(frame_ready),
    .dry_sample (dry_sample),
    .wet_sample (wet_sample),
    .change_en  (change_en),
    .rising_tone(rising_tone),
    .proc_reset (proc_reset),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frames arrive every 10 cycles; the expected play sample is queued at issue.
  task automatic do_frame(input int exp);
    repeat (9) @(negedge clk);
    exp_q.push_back(exp);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("out_valid_latency", int'(out_valid), 1);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0d, expected no output", $signed(out_sample));
      end else begin
        check("out_sample", int'($signed(out_sample)), exp_q.pop_front());
      end
    end
    if (proc_reset) begin
      pr_count++;
      pr_chg  = change_en;
      pr_rise = rising_tone;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic busy_seen;
    int   t;
    reset       = 1'b1;
    sw_change   = 1'b0;
    sw_rise     = 1'b0;
    frame_ready = 1'b0;
    dry_sample  = 16'd1000;
    wet_sample  = 16'd1000;
    repeat (3) @(negedge clk);
    check("rst_change_en",   int'(change_en),   0);
    check("rst_rising_tone", int'(rising_tone), 0);
    check("rst_proc_reset",  int'(proc_reset),  0);
    check("rst_out_sample",  int'(out_sample),  0);
    check("rst_out_valid",   int'(out_valid),   0);
    check("rst_busy",        int'(busy),        0);
    reset = 1'b0;
    do_frame(1000);

    // Bouncing switch must never reach the controller.
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw_change = ~sw_change;
      repeat (2) begin
        @(negedge clk);
        if (busy) busy_seen = 1'b1;
      end
    end
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("bounce_busy", int'(busy_seen), 0);
    sw_change = 1'b1;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("busy_rise", int'(busy), 1);

    // Abort at gain 128: ramp back up without switching.
    do_frame(1000);
    do_frame(750);
    sw_change = 1'b0;
    do_frame(500);
    do_frame(750);
    do_frame(1000);
    check("abort_proc_reset_cnt", pr_count, 0);
    check("abort_change_en", int'(change_en), 0);
    check("abort_busy", int'(busy), 0);

    // Full switch sequence.
    sw_change = 1'b1;
    do_frame(1000);
    do_frame(750);
    do_frame(500);
    do_frame(250);
    check("change_en_before_switch", int'(change_en), 0);
    do_frame(0);
    do_frame(0);
    do_frame(0);
    do_frame(250);
    do_frame(500);
    do_frame(750);
    do_frame(1000);
    check("switch_proc_reset_cnt", pr_count, 1);
    check("switch_change_en_at_pulse", int'(pr_chg), 1);
    check("switch_change_en", int'(change_en), 1);
    check("switch_busy", int'(busy), 0);

    // Negative full-scale samples through the wet path, then re-request in FADE_IN.
    wet_sample = 16'h8000;
    sw_change  = 1'b0;
    do_frame(-32768);
    do_frame(-24576);
    do_frame(-16384);
    do_frame(-8192);
    do_frame(0);
    do_frame(0);
    do_frame(0);
    do_frame(250);
    sw_change = 1'b1;
    sw_rise   = 1'b1;
    do_frame(500);
    do_frame(250);
    do_frame(0);
    do_frame(0);
    do_frame(0);
    do_frame(-8192);
    do_frame(-16384);
    do_frame(-24576);
    do_frame(-32768);
    check("rereq_proc_reset_cnt", pr_count, 3);
    check("rereq_change_en_at_pulse", int'(pr_chg), 1);
    check("rereq_rising_at_pulse", int'(pr_rise), 1);
    check("rereq_rising_tone", int'(rising_tone), 1);
    check("rereq_change_en", int'(change_en), 1);
    check("rereq_busy", int'(busy), 0);

    // Reset in the middle of FADE_IN.
    sw_change = 1'b0;
    sw_rise   = 1'b0;
    do_frame(-32768);
    do_frame(-24576);
    do_frame(-16384);
    do_frame(-8192);
    do_frame(0);
    do_frame(0);
    do_frame(0);
    do_frame(250);
    check("midfade_busy", int'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_sample", int'(out_sample), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_change_en", int'(change_en), 0);
    check("midrst_proc_reset", int'(proc_reset), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_frame(1000);
    check("midrst_proc_reset_cnt", pr_count, 4);
    check("midrst_busy_after", int'(busy), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
